// File: rtl/vx_mem_responder_pkg.sv
// vx_mem_responder_pkg: shared request kinds and sizing helper for the memory responder
package vx_mem_responder_pkg;
  typedef enum logic {REQ_READ = 1'b0, REQ_WRITE = 1'b1} req_kind_e;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vx_mem_responder_if.sv
// vx_mem_responder_if: line-granular memory request/response bus
interface vx_mem_responder_if #(
  parameter int DATA_SIZE  = 64,
  parameter int TAG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 32 - $clog2(DATA_SIZE)
);
  logic                   req_valid;
  logic                   req_rw;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_SIZE*8-1:0] req_data;
  logic [DATA_SIZE-1:0]   req_byteen;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   req_ready;
  logic                   rsp_valid;
  logic [DATA_SIZE*8-1:0] rsp_data;
  logic [TAG_WIDTH-1:0]   rsp_tag;
  logic                   rsp_ready;
  modport master (
    output req_valid, req_rw, req_addr, req_data, req_byteen, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );
  modport slave (
    input  req_valid, req_rw, req_addr, req_data, req_byteen, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/vx_mem_responder_fifo.sv
// vx_mem_responder_fifo: registered response queue; caller guarantees no push when full
module vx_mem_responder_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] slots [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign head = slots[rd_ptr];
  // occupancy, pointers and the registered not-empty flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop) rd_ptr <= bump(rd_ptr);
      count <= count_nxt;
      valid <= count_nxt != '0;
    end
  end
  // entry storage, never reset
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/vx_mem_responder.sv
// vx_mem_responder: memory-side slave with fixed read latency and credit-guarded response queue
module vx_mem_responder
  import vx_mem_responder_pkg::*;
#(
  parameter int DATA_SIZE      = 64,
  parameter int ADDR_WIDTH     = 32 - $clog2(DATA_SIZE),
  parameter int TAG_WIDTH      = 8,
  parameter int NUM_LINES      = 1024,
  parameter int LATENCY        = 4,
  parameter int RSP_QUEUE_SIZE = 8
) (
  input logic              clk,
  input logic              reset,
  vx_mem_responder_if.slave mem_bus_if
);
  localparam int DW = DATA_SIZE * 8;
  localparam int IW = clog2_min1(NUM_LINES);
  localparam int EW = TAG_WIDTH + DW;
  localparam int CW = $clog2(RSP_QUEUE_SIZE + 1);
  logic [DW-1:0]      mem [NUM_LINES];
  logic [CW-1:0]      outstanding;
  logic [LATENCY-1:0] dl_valid;
  logic [EW-1:0]      dl_data [LATENCY];
  logic [EW-1:0]      rsp_head;
  logic [IW-1:0]      idx;
  logic               fire;
  logic               rd_fire;
  logic               wr_fire;
  logic               rsp_fire;
  assign idx      = mem_bus_if.req_addr[IW-1:0];
  assign mem_bus_if.req_ready = !reset && (outstanding < CW'(RSP_QUEUE_SIZE));
  assign fire     = mem_bus_if.req_valid && mem_bus_if.req_ready;
  assign rd_fire  = fire && (mem_bus_if.req_rw == REQ_READ);
  assign wr_fire  = fire && (mem_bus_if.req_rw == REQ_WRITE);
  assign rsp_fire = mem_bus_if.rsp_valid && mem_bus_if.rsp_ready;
  assign {mem_bus_if.rsp_tag, mem_bus_if.rsp_data} = rsp_head;
  if (ADDR_WIDTH > IW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_bus_if.req_addr[ADDR_WIDTH-1:IW];
  end
  // byte-enabled line writes; upper address bits alias onto the same lines
  always_ff @(posedge clk) begin
    if (wr_fire)
      for (int i = 0; i < DATA_SIZE; i++)
        if (mem_bus_if.req_byteen[i]) mem[idx][i*8 +: 8] <= mem_bus_if.req_data[i*8 +: 8];
  end
  // read credit: bounds delay-line plus queue occupancy so the queue never overflows
  always_ff @(posedge clk) begin
    if (reset) outstanding <= '0;
    else outstanding <= outstanding + CW'(rd_fire) - CW'(rsp_fire);
  end
  // delay-line valids, cleared on reset so in-flight reads are dropped
  always_ff @(posedge clk) begin
    if (reset) dl_valid <= '0;
    else begin
      dl_valid[0] <= rd_fire;
      for (int i = 1; i < LATENCY; i++) dl_valid[i] <= dl_valid[i-1];
    end
  end
  // delay-line payload; storage is sampled at acceptance so earlier writes are visible
  always_ff @(posedge clk) begin
    dl_data[0] <= {mem_bus_if.req_tag, mem[idx]};
    for (int i = 1; i < LATENCY; i++) dl_data[i] <= dl_data[i-1];
  end
  vx_mem_responder_fifo #(.WIDTH(EW), .DEPTH(RSP_QUEUE_SIZE)) rsp_queue (
    .clk       (clk),
    .rst       (reset),
    .push      (dl_valid[LATENCY-1]),
    .push_data (dl_data[LATENCY-1]),
    .pop       (rsp_fire),
    .valid     (mem_bus_if.rsp_valid),
    .head      (rsp_head)
  );
endmodule
